// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, in-order imem reads, small instruction FIFO,
// registered insn/pc to decode. Define FETCH_PERF_EN to add fetch/bubble perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        enable_decode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     ret_pc_q, ret_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     buf_insn_q [BUF_DEPTH];
  logic [31:0]     buf_pc_q   [BUF_DEPTH];
  logic [31:0]     insn_q, insn_d;
  logic [31:0]     pc_q, pc_d;
  logic            valid_q, valid_d;

  logic            accept, push, pop;
  logic [CntW-1:0] inflight_after;
  logic [CntW:0]   credits_used;

  // Requests still owed to us once this cycle's response (if any) is consumed.
  assign inflight_after = outstanding_q - CntW'(imem_rvalid);
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, count_q};

  assign imem_req  = (state_q == StRun) && (credits_used < (CntW + 1)'(BUF_DEPTH)) &&
                     !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign push      = imem_rvalid && !redirect_valid && (discard_q == '0);
  assign pop       = !redirect_valid && !stall && (count_q != '0);

  assign insn          = insn_q;
  assign pc            = pc_q;
  assign enable_decode = valid_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    ret_pc_d      = ret_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    insn_d        = insn_q;
    pc_d          = pc_q;
    valid_d       = valid_q;

    if (redirect_valid) begin
      // Flush wins over stall and over any word returning this cycle.
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      ret_pc_d      = {redirect_pc[31:2], 2'b00};
      discard_d     = inflight_after;
      outstanding_d = inflight_after;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      valid_d       = 1'b0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CntW'(accept) - CntW'(imem_rvalid);
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        ret_pc_d = ret_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        insn_d   = buf_insn_q[rd_ptr_q];
        pc_d     = buf_pc_q[rd_ptr_q];
        valid_d  = 1'b1;
      end else if (!stall) begin
        valid_d = 1'b0;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   if (redirect_valid && (inflight_after != '0)) state_d = StDrain;
      StDrain: if (discard_d == '0) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      ret_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      insn_q        <= '0;
      pc_q          <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      ret_pc_q      <= ret_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      insn_q        <= insn_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_insn_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]   <= ret_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if ((state_q == StRun) && !stall && (count_q == '0)) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Credit accounting makes this unreachable; firing means the bookkeeping broke.
  push_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count_q == CntW'(BUF_DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req, imem_ready, imem_rvalid, stall, redirect_valid, enable_decode;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, insn, pc;

  logic        req2, rvalid2, en2;
  logic [31:0] addr2, rdata2, insn2, pc2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(ResetPc), .BUF_DEPTH(Depth)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .insn(insn), .pc(pc), .enable_decode(enable_decode)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(Depth)) dut_wrap (
    .clock(clock), .reset_n(reset_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .insn(insn2), .pc(pc2), .enable_decode(en2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  // Fixed one-cycle memory for the wrap-around instance.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid2 <= 1'b0;
      rdata2  <= 32'h0;
    end else begin
      rvalid2 <= req2;
      rdata2  <= mem_word(addr2);
    end
  end

  logic [31:0] wrap_pcs [3];
  int          wrap_n = 0;
  always @(negedge clock) begin
    if (reset_n && en2 && wrap_n < 3) begin
      wrap_pcs[wrap_n] = pc2;
      wrap_n++;
    end
  end

  // Reference model: architectural view of the fetch stream.
  logic [31:0] m_if_pc [$];
  bit          m_if_drop [$];
  logic [31:0] m_fifo [$];
  logic [31:0] m_fetch_pc, m_out_pc, m_out_insn;
  logic        m_out_valid, m_started;

  // Memory responder for the main instance.
  logic [31:0] r_data [$];
  int          r_due [$];
  int          lat_min = 1, lat_max = 1;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_pc.delete();
    m_if_drop.delete();
    m_fifo.delete();
    r_data.delete();
    r_due.delete();
    m_fetch_pc  = ResetPc;
    m_out_pc    = 32'h0;
    m_out_insn  = 32'h0;
    m_out_valid = 1'b0;
    m_started   = 1'b0;
  endtask

  function automatic bit resp_now();
    return (r_due.size() > 0) && (r_due[0] <= cyc);
  endfunction

  function automatic bit m_draining();
    foreach (m_if_drop[i]) if (m_if_drop[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_cycle(input logic st, input logic rd, input logic [31:0] rpc,
                           input logic rdy);
    logic        exp_req, resp, hd_drop;
    logic [31:0] hd_pc, dummy;
    int          due, dummy_i;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    resp           = resp_now();
    imem_rvalid    = resp;
    imem_rdata     = resp ? r_data[0] : 32'hDEAD_BEEF;
    #1;
    exp_req = m_started && !m_draining() && !rd &&
              ((m_if_pc.size() + m_fifo.size()) < Depth);
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);

    if (resp) begin
      dummy   = r_data.pop_front();
      dummy_i = r_due.pop_front();
    end
    if (imem_req && imem_ready) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (r_due.size() > 0 && due <= r_due[$]) due = r_due[$] + 1;
      r_due.push_back(due);
      r_data.push_back(mem_word(imem_addr));
    end

    if (rd) begin
      if (resp && m_if_pc.size() > 0) begin
        hd_pc   = m_if_pc.pop_front();
        hd_drop = m_if_drop.pop_front();
      end
      foreach (m_if_drop[i]) m_if_drop[i] = 1'b1;
      m_fifo.delete();
      m_fetch_pc  = {rpc[31:2], 2'b00};
      m_out_valid = 1'b0;
    end else begin
      if (!st && m_fifo.size() > 0) begin
        m_out_pc    = m_fifo.pop_front();
        m_out_insn  = mem_word(m_out_pc);
        m_out_valid = 1'b1;
      end else if (!st) begin
        m_out_valid = 1'b0;
      end
      if (resp && m_if_pc.size() > 0) begin
        hd_pc   = m_if_pc.pop_front();
        hd_drop = m_if_drop.pop_front();
        if (!hd_drop) m_fifo.push_back(hd_pc);
      end
      if (exp_req && rdy) begin
        m_if_pc.push_back(m_fetch_pc);
        m_if_drop.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_started = 1'b1;
    cyc++;

    @(posedge clock);
    #1;
    chk("enable_decode", {31'h0, enable_decode}, {31'h0, m_out_valid});
    chk("pc", pc, m_out_pc);
    chk("insn", insn, m_out_insn);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable_decode"}, {31'h0, enable_decode}, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_insn"}, insn, 32'h0);
    chk({tag, "_imem_req"}, {31'h0, imem_req}, 32'h0);
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
  endtask

  initial begin
    bit found;
    idle_inputs();
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Streaming with single-cycle memory; first insn reaches decode four edges after release.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 3) begin
        chk("first_valid", {31'h0, enable_decode}, 32'h1);
        chk("first_pc", pc, ResetPc);
      end
    end
    chk("wrap_count", wrap_n, 3);
    chk("wrap_pc0", wrap_pcs[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", wrap_pcs[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", wrap_pcs[2], 32'h0000_0000);

    // Long stall fills the FIFO; release must resume without loss or duplication.
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_full_req", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_if_pc.size() == 2 && !m_draining()) found = 1'b1;
      else run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("two_in_flight", {31'h0, found}, 32'h1);
    if (found) begin
      run_cycle(1'b0, 1'b1, 32'h0040_0103, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if (enable_decode) found = 1'b1;
      end
      chk("redir_delivered", {31'h0, found}, 32'h1);
      chk("redir_first_pc", pc, 32'h0040_0100);
    end

    // Redirect colliding with a returning word while decode is stalled.
    lat_min = 1; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (resp_now()) found = 1'b1;
      else run_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("collide_found", {31'h0, found}, 32'h1);
    if (found) begin
      run_cycle(1'b1, 1'b1, 32'h0040_0800, 1'b1);
      chk("collide_enable", {31'h0, enable_decode}, 32'h0);
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic, with an asynchronous reset partway through.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
      end
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode stage. Maintains the program counter and issues in-order word reads to instruction memory. Buffers returned instructions in a small FIFO and presents one registered insn/pc pair per cycle to decode, qualified by enable_decode. Handles branch/jump redirects by flushing buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
BUF_DEPTH, 2, instruction FIFO entries and max outstanding requests (power of 2, >=2).

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  read request valid
imem_addr  output  32  word-aligned read address (= current pc)
imem_ready  input  1  request accepted when imem_req && imem_ready
imem_rvalid  input  1  read data valid; responses return in request order, >=1 cycle after acceptance
imem_rdata  input  32  instruction word
stall  input  1  decode cannot accept; hold outputs
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  target PC; bits [1:0] ignored (forced 0)
insn  output  32  instruction to decode
pc  output  32  PC of insn
enable_decode  output  1  insn/pc valid this cycle

Behaviour:
- Reset (async, reset_n=0): state=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, insn=0, pc=0, enable_decode=0, imem_req=0.
- FSM: IDLE -> RUN on first clock after reset release. RUN -> DRAIN on redirect_valid when in-flight responses exist (outstanding minus this cycle's return > 0); else stays RUN. DRAIN -> RUN when discard count reaches 0. redirect_valid in IDLE or DRAIN: fetch_pc updated, flush applied, state rules unchanged.
- Issue: in RUN, imem_req=1 iff outstanding + FIFO count < BUF_DEPTH and redirect_valid=0. imem_addr=fetch_pc. On handshake: fetch_pc += 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), outstanding++. No requests in IDLE/DRAIN.
- Return: imem_rvalid with discard>0 -> word dropped, discard--. Otherwise word pushed with its PC (tracked by separate ret_pc counter advanced +4 per accepted response). Credit rule guarantees FIFO never overflows; a push to a full FIFO is a design error (assert in sim).
- Output (registered, 1-cycle min latency FIFO-head to outputs): if stall=0: FIFO non-empty -> pop head into insn/pc, enable_decode=1; empty -> enable_decode=0, insn/pc hold. If stall=1: insn/pc/enable_decode hold, no pop. Simultaneous push+pop on same cycle allowed, including when FIFO was empty (push lands, pops next cycle).
- Redirect (priority over everything): same edge -> FIFO flushed, enable_decode=0, fetch_pc=ret_pc={redirect_pc[31:2],2'b00}, discard=outstanding minus any response returning this cycle, outstanding set to discard. Any imem_rvalid in the redirect cycle is dropped. stall ignored for the flush.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight responses after release are the environment's responsibility (memory is reset together).

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched (32b, increments per pop to decode) and perf_bubbles (32b, increments each RUN cycle with stall=0 and FIFO empty); both reset to 0, wrap at 2^32, cleared also on redirect? No - never cleared except reset. When undefined, ports and counters absent; core behaviour identical.

Test Plan:
- Reset release, imem_ready=1, 1-cycle rvalid latency, stall=0 -> addresses 0x00400000, 0x00400004, ...; decode sees pc=0x00400000 with enable_decode=1 by cycle 3, then one insn per cycle back-to-back.
- stall held 5 cycles with FIFO full -> imem_req=0, insn/pc/enable_decode unchanged; on release, sequential pcs resume with no loss/duplication.
- Redirect to 0x00400103 with 2 requests in flight -> state DRAIN, next 2 rvalid words dropped, next request addr 0x00400100, first decoded pc 0x00400100.
- redirect_valid and imem_rvalid same cycle, stall=1 -> returning word dropped, enable_decode=0 next cycle, no stale insn issued.
- RESET_PC=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset_n pulsed low mid-stream (async, between edges) -> outputs 0 / enable_decode=0 immediately, restart at RESET_PC.
